lsu_mem_arbiter: RTL and testbench

//  Sequences and shares the single data-memory port (port 2) between the load and store functional units.

---
 rtl/lsu_mem_arbiter_pkg.sv | 37 +++
 rtl/lsu_rr_pick.sv | 54 +++++
 rtl/lsu_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU data-memory port arbiter.
//   RS_tag_type / INVALID : reservation-station tag carried on the CDB
//   lsu_arb_state_t       : arbiter FSM states
//   lsu_rr_t              : round-robin pointer (which requester is favoured)
//   MemSize* / helpers    : field encodings of the {sign_n, size[1:0]} memory type
package lsu_mem_arbiter_pkg;

  localparam int unsigned RS_TAG_W = 4;
  typedef logic [RS_TAG_W-1:0] RS_tag_type;
  // All-ones marks "no broadcast" on the CDB.
  localparam RS_tag_type INVALID = '1;

  typedef enum logic [1:0] {
    StIdle,
    StLdWait,
    StLdBcast,
    StStWr
  } lsu_arb_state_t;

  typedef enum logic {
    RrLoad  = 1'b0,
    RrStore = 1'b1
  } lsu_rr_t;

  localparam logic [1:0] MemSizeByte = 2'b00;
  localparam logic [1:0] MemSizeHalf = 2'b01;
  localparam logic [1:0] MemSizeWord = 2'b10;

  function automatic logic [1:0] mem_type_size(input logic [2:0] mem_type);
    return mem_type[1:0];
  endfunction

  function automatic logic mem_type_sign_n(input logic [2:0] mem_type);
    return mem_type[2];
  endfunction

endpackage

// File: rtl/lsu_rr_pick.sv
// Two-requester round-robin picker (load vs store).
//   i_clk, i_rst       : clock, asynchronous active-high reset (pointer -> RrLoad)
//   i_en               : a grant may be issued this cycle
//   i_ld_req, i_st_req : requests
//   o_ld_win, o_st_win : one-hot (or zero) winner
// A lone request always wins; on contention the pointer decides. After any grant the
// pointer moves to favour the requester that did not win.
module lsu_rr_pick
  import lsu_mem_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_ld_req,
  input  logic i_st_req,
  output logic o_ld_win,
  output logic o_st_win
);

  lsu_rr_t r_ptr;
  lsu_rr_t w_ptr_d;

  always_comb begin
    o_ld_win = 1'b0;
    o_st_win = 1'b0;
    if (i_en) begin
      if (i_ld_req && i_st_req) begin
        o_ld_win = (r_ptr == RrLoad);
        o_st_win = (r_ptr == RrStore);
      end else begin
        o_ld_win = i_ld_req;
        o_st_win = i_st_req;
      end
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    if (o_ld_win) begin
      w_ptr_d = RrStore;
    end else if (o_st_win) begin
      w_ptr_d = RrLoad;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= RrLoad;
    end else begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares data-memory port 2 between the load and store units and broadcasts load
// results (value + RS tag) on the CDB, holding them until accepted.
// Optional feature macro: LSU_ARB_PERF_EN adds 32-bit performance counters.
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_ld_req/addr/type/tag, o_ld_gnt  load request; o_ld_gnt pulses on issue
//   i_st_req/addr/data/size, o_st_gnt store request; o_st_gnt pulses on write
//   i_flush                         squash the in-flight load
//   o_mem_addr2/din2/size/sign/rden2/we2, i_mem_dout2   memory port 2
//   o_cdb_val/tag/req, i_cdb_ack    CDB broadcast handshake
//   o_busy                          FSM not idle
//   o_perf_ld_cnt/st_cnt/stall_cnt  (LSU_ARB_PERF_EN only) grant and stall counters
// Parameter READ_LAT (1..7): cycles from read enable to valid i_mem_dout2.
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_req,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_type,
  input  RS_tag_type  i_ld_tag,
  output logic        o_ld_gnt,
  input  logic        i_st_req,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_st_size,
  output logic        o_st_gnt,
  input  logic        i_flush,
  output logic [31:0] o_mem_addr2,
  output logic [31:0] o_mem_din2,
  output logic [1:0]  o_mem_size,
  output logic        o_mem_sign,
  output logic        o_mem_rden2,
  output logic        o_mem_we2,
  input  logic [31:0] i_mem_dout2,
  output logic [31:0] o_cdb_val,
  output RS_tag_type  o_cdb_tag,
  output logic        o_cdb_req,
  input  logic        i_cdb_ack,
  output logic        o_busy
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [31:0] o_perf_ld_cnt,
  output logic [31:0] o_perf_st_cnt,
  output logic [31:0] o_perf_stall_cnt
`endif
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] LatInit = CntW'(READ_LAT);

  lsu_arb_state_t r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_dec;
  RS_tag_type      r_tag, w_tag_d;
  logic [31:0]     r_val, w_val_d;
  logic            r_squash, w_squash_d;
  logic            w_ld_win, w_st_win, w_pick_en;

  // Gating with i_rst keeps every output quiet while reset is held, even if the
  // requesters keep their request lines high.
  assign w_pick_en = (r_state == StIdle) && !i_rst;
  assign w_cnt_dec = r_cnt - CntW'(1);
  assign o_busy    = (r_state != StIdle);

  lsu_rr_pick u_rr_pick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_pick_en),
    .i_ld_req (i_ld_req),
    .i_st_req (i_st_req),
    .o_ld_win (w_ld_win),
    .o_st_win (w_st_win)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_tag_d     = r_tag;
    w_val_d     = r_val;
    w_squash_d  = r_squash;
    o_mem_addr2 = '0;
    o_mem_din2  = '0;
    o_mem_size  = '0;
    o_mem_sign  = 1'b0;
    o_mem_rden2 = 1'b0;
    o_mem_we2   = 1'b0;
    o_ld_gnt    = 1'b0;
    o_st_gnt    = 1'b0;
    o_cdb_req   = 1'b0;
    o_cdb_val   = '0;
    o_cdb_tag   = INVALID;

    unique case (r_state)
      StIdle: begin
        if (w_ld_win) begin
          o_mem_addr2 = i_ld_addr;
          o_mem_size  = mem_type_size(i_ld_type);
          o_mem_sign  = mem_type_sign_n(i_ld_type);
          o_mem_rden2 = 1'b1;
          o_ld_gnt    = 1'b1;
          w_tag_d     = i_ld_tag;
          w_cnt_d     = LatInit;
          w_squash_d  = 1'b0;
          w_state_d   = StLdWait;
        end else if (w_st_win) begin
          o_mem_addr2 = i_st_addr;
          o_mem_din2  = i_st_data;
          o_mem_size  = i_st_size;
          o_mem_we2   = 1'b1;
          o_st_gnt    = 1'b1;
          w_state_d   = StStWr;
        end
      end

      StLdWait: begin
        w_cnt_d = w_cnt_dec;
        if (i_flush) begin
          w_squash_d = 1'b1;
        end
        // Last wait cycle: memory data is valid now, so the broadcast starts next
        // cycle, READ_LAT+1 cycles after the grant.
        if (w_cnt_dec == '0) begin
          w_squash_d = 1'b0;
          if (r_squash || i_flush) begin
            w_state_d = StIdle;
          end else begin
            w_val_d   = i_mem_dout2;
            w_state_d = StLdBcast;
          end
        end
      end

      StLdBcast: begin
        o_cdb_val = r_val;
        o_cdb_tag = r_tag;
        o_cdb_req = !i_flush;
        if (i_flush || i_cdb_ack) begin
          w_state_d = StIdle;
        end
      end

      StStWr: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_tag    <= INVALID;
      r_val    <= '0;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_tag    <= w_tag_d;
      r_val    <= w_val_d;
      r_squash <= w_squash_d;
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [31:0] r_perf_ld, r_perf_st, r_perf_stall;
  logic        w_stall;

  assign w_stall = (i_ld_req || i_st_req) && !o_ld_gnt && !o_st_gnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_ld    <= '0;
      r_perf_st    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (o_ld_gnt) begin
        r_perf_ld <= r_perf_ld + 32'd1;
      end
      if (o_st_gnt) begin
        r_perf_st <= r_perf_st + 32'd1;
      end
      if (w_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign o_perf_ld_cnt    = r_perf_ld;
  assign o_perf_st_cnt    = r_perf_st;
  assign o_perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: a synchronous memory model behind port 2,
// a reference memory image for expected load data, and a scoreboard of expected
// CDB broadcasts.
module tb_lsu_mem_arbiter;
  import lsu_mem_arbiter_pkg::*;

  localparam int unsigned READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req, st_req, flush, cdb_ack;
  logic [31:0] ld_addr, st_addr, st_data;
  logic [2:0]  ld_type;
  logic [1:0]  st_size;
  RS_tag_type  ld_tag;
  logic        ld_gnt, st_gnt;
  logic [31:0] mem_addr2, mem_din2, mem_dout2, cdb_val;
  logic [1:0]  mem_size;
  logic        mem_sign, mem_rden2, mem_we2, cdb_req, busy;
  RS_tag_type  cdb_tag;

  typedef struct {
    RS_tag_type  tag;
    logic [31:0] val;
  } bc_t;

  bc_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [7:0]  rd_pipe [0:READ_LAT-1];

  lsu_mem_arbiter #(.READ_LAT(READ_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ld_req    (ld_req),
    .i_ld_addr   (ld_addr),
    .i_ld_type   (ld_type),
    .i_ld_tag    (ld_tag),
    .o_ld_gnt    (ld_gnt),
    .i_st_req    (st_req),
    .i_st_addr   (st_addr),
    .i_st_data   (st_data),
    .i_st_size   (st_size),
    .o_st_gnt    (st_gnt),
    .i_flush     (flush),
    .o_mem_addr2 (mem_addr2),
    .o_mem_din2  (mem_din2),
    .o_mem_size  (mem_size),
    .o_mem_sign  (mem_sign),
    .o_mem_rden2 (mem_rden2),
    .o_mem_we2   (mem_we2),
    .i_mem_dout2 (mem_dout2),
    .o_cdb_val   (cdb_val),
    .o_cdb_tag   (cdb_tag),
    .o_cdb_req   (cdb_req),
    .i_cdb_ack   (cdb_ack),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory with registered address: data for an address presented at cycle N is
  // visible at cycle N+READ_LAT.
  always @(posedge clk) begin
    if (mem_we2) mem[mem_addr2[9:2]] <= mem_din2;
    rd_pipe[0] <= mem_addr2[9:2];
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout2 = mem[rd_pipe[READ_LAT-1]];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [31:0] a, input RS_tag_type t, input bit push,
                            input string nm);
    bc_t e;
    ld_req = 1'b1; ld_addr = a; ld_type = 3'b010; ld_tag = t;
    #1;
    checks++;
    if (ld_gnt !== 1'b1 || mem_rden2 !== 1'b1 || mem_addr2 !== a) begin
      failures++;
      $display("FAIL %s_grant: gnt=%b rden=%b addr=%h required gnt=1 rden=1 addr=%h",
               nm, ld_gnt, mem_rden2, mem_addr2, a);
    end
    if (push) begin
      e.tag = t; e.val = ref_mem[a[9:2]];
      sb.push_back(e);
    end
    cyc();
    ld_req = 1'b0;
  endtask

  // Entered one cycle after a load grant; waits for the broadcast, checks its latency
  // and contents against the scoreboard, then acknowledges it.
  task automatic collect_bcast(input string nm);
    int  k = 1;
    bit  seen = 0;
    bc_t e;
    while (k <= 20 && !seen) begin
      #1;
      if (cdb_req === 1'b1) seen = 1;
      else begin cyc(); k++; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no CDB_REQ within 20 cycles, required one", nm);
      return;
    end
    if (k != READ_LAT + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", nm, k, READ_LAT + 1);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected: broadcast tag=%0d with empty scoreboard", nm, cdb_tag);
    end else begin
      e = sb.pop_front();
      if (cdb_tag !== e.tag || cdb_val !== e.val) begin
        failures++;
        $display("FAIL %s_data: tag=%0d val=%h required tag=%0d val=%h",
                 nm, cdb_tag, cdb_val, e.tag, e.val);
      end
    end
    cdb_ack = 1'b1;
    cyc();
    cdb_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cdb_tag !== INVALID) begin
      failures++;
      $display("FAIL %s_release: busy=%b tag=%0d required busy=0 tag=%0d",
               nm, busy, cdb_tag, INVALID);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ld_req = 1'b1; st_req = 1'b1;
    repeat (3) cyc();
    checks++;
    if (ld_gnt !== 1'b0 || st_gnt !== 1'b0 || mem_rden2 !== 1'b0 || mem_we2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt: ld=%b st=%b rden=%b we=%b required all 0",
               ld_gnt, st_gnt, mem_rden2, mem_we2);
    end
    checks++;
    if (busy !== 1'b0 || cdb_req !== 1'b0 || cdb_tag !== INVALID || cdb_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_cdb: busy=%b req=%b tag=%0d val=%h required 0 0 %0d 0",
               busy, cdb_req, cdb_tag, cdb_val, INVALID);
    end
    ld_req = 1'b0; st_req = 1'b0; rst = 1'b0;
    cyc();
  endtask

  task automatic test_load_basic();
    bc_t e;
    ld_req = 1'b1; ld_addr = 32'h100; ld_type = 3'b101; ld_tag = 4'd3;
    #1;
    checks++;
    if (ld_gnt !== 1'b1 || mem_rden2 !== 1'b1 || mem_addr2 !== 32'h100) begin
      failures++;
      $display("FAIL load_basic_grant: gnt=%b rden=%b addr=%h required 1 1 00000100",
               ld_gnt, mem_rden2, mem_addr2);
    end
    checks++;
    if (mem_size !== 2'b01 || mem_sign !== 1'b1 || mem_we2 !== 1'b0) begin
      failures++;
      $display("FAIL load_basic_type: size=%b sign=%b we=%b required 01 1 0",
               mem_size, mem_sign, mem_we2);
    end
    e.tag = 4'd3; e.val = ref_mem[8'h40];
    sb.push_back(e);
    cyc();
    ld_req = 1'b0;
    collect_bcast("load_basic");
  endtask

  task automatic test_store();
    st_req = 1'b1; st_addr = 32'h200; st_data = 32'hDEADBEEF; st_size = 2'b10;
    #1;
    checks++;
    if (st_gnt !== 1'b1 || mem_we2 !== 1'b1 || mem_din2 !== 32'hDEADBEEF ||
        mem_addr2 !== 32'h200 || mem_size !== 2'b10) begin
      failures++;
      $display("FAIL store_grant: gnt=%b we=%b din=%h addr=%h size=%b required 1 1 deadbeef %s",
               st_gnt, mem_we2, mem_din2, mem_addr2, mem_size, "00000200 10");
    end
    ref_mem[8'h80] = 32'hDEADBEEF;
    cyc();
    st_req = 1'b0;
    #1;
    checks++;
    if (st_gnt !== 1'b0 || mem_we2 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL store_one_cycle: gnt=%b we=%b busy=%b required 0 0 1",
               st_gnt, mem_we2, busy);
    end
    cyc();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL store_done: busy=%b required 0", busy);
    end
    issue_load(32'h200, 4'd5, 1'b1, "store_readback");
    collect_bcast("store_readback");
  endtask

  task automatic test_arbitration();
    int  k = 0;
    bit  got = 0;
    bit  early = 0;
    bc_t e;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h104; ld_type = 3'b010; ld_tag = 4'd1;
    st_req = 1'b1; st_addr = 32'h208; st_data = 32'h12345678; st_size = 2'b10;
    #1;
    checks++;
    if (ld_gnt !== 1'b1 || st_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rr_first_load: ld=%b st=%b required ld=1 st=0", ld_gnt, st_gnt);
    end
    e.tag = 4'd1; e.val = ref_mem[8'h41];
    sb.push_back(e);
    cyc();
    ld_req = 1'b0;
    while (k < 20 && !got) begin
      #1;
      if (busy === 1'b1) begin
        if (st_gnt !== 1'b0) early = 1;
        if (cdb_req === 1'b1) begin
          e = sb.pop_front();
          checks++;
          if (cdb_tag !== e.tag || cdb_val !== e.val) begin
            failures++;
            $display("FAIL rr_load_data: tag=%0d val=%h required tag=%0d val=%h",
                     cdb_tag, cdb_val, e.tag, e.val);
          end
          cdb_ack = 1'b1;
        end
        cyc();
        cdb_ack = 1'b0;
        k++;
      end else begin
        got = 1;
      end
    end
    checks++;
    if (!got || early || st_gnt !== 1'b1 || mem_we2 !== 1'b1) begin
      failures++;
      $display("FAIL rr_store_at_idle: idle=%b early=%b st_gnt=%b we=%b required 1 0 1 1",
               got, early, st_gnt, mem_we2);
    end
    ref_mem[8'h82] = 32'h12345678;
    cyc();
    st_req = 1'b0;
    cyc();
    issue_load(32'h208, 4'd2, 1'b1, "rr_lone_load");
    collect_bcast("rr_lone_load");
    ld_req = 1'b1; ld_addr = 32'h10C; ld_tag = 4'd8;
    st_req = 1'b1; st_addr = 32'h20C; st_data = 32'hCAFEF00D;
    #1;
    checks++;
    if (st_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rr_second_store: ld=%b st=%b required ld=0 st=1", ld_gnt, st_gnt);
    end
    ref_mem[8'h83] = 32'hCAFEF00D;
    cyc();
    ld_req = 1'b0; st_req = 1'b0;
    cyc();
    #1;
    checks++;
    if (busy !== 1'b0 || ld_gnt !== 1'b0 || mem_rden2 !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_req: busy=%b ld_gnt=%b rden=%b required all 0",
               busy, ld_gnt, mem_rden2);
    end
    cyc();
  endtask

  task automatic test_flush();
    bit saw = 0;
    bit seen = 0;
    int k = 0;
    issue_load(32'h110, 4'd6, 1'b0, "flush_wait");
    for (int c = 1; c <= READ_LAT + 3; c++) begin
      if (c == 1) flush = 1'b1;
      #1;
      if (cdb_req !== 1'b0) saw = 1;
      if (c == READ_LAT) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL flush_wait_busy: busy=%b at cycle %0d required 1", busy, c);
        end
      end
      if (c == READ_LAT + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL flush_wait_release: busy=%b at cycle %0d required 0", busy, c);
        end
      end
      cyc();
      flush = 1'b0;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL flush_wait_nobcast: CDB_REQ seen=1 required 0");
    end
    issue_load(32'h114, 4'd7, 1'b0, "flush_bcast");
    while (k < 20 && !seen) begin
      #1;
      if (cdb_req === 1'b1) seen = 1;
      else begin cyc(); k++; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL flush_bcast_timeout: no CDB_REQ within 20 cycles, required one");
    end
    flush = 1'b1;
    #1;
    checks++;
    if (cdb_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_bcast_drop: req=%b required 0", cdb_req);
    end
    cyc();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || cdb_tag !== INVALID) begin
      failures++;
      $display("FAIL flush_bcast_idle: busy=%b tag=%0d required 0 %0d", busy, cdb_tag, INVALID);
    end
  endtask

  task automatic test_cdb_hold();
    bit  seen = 0;
    int  k = 0;
    bc_t e;
    issue_load(32'h118, 4'd9, 1'b1, "cdb_hold");
    while (k < 20 && !seen) begin
      #1;
      if (cdb_req === 1'b1) seen = 1;
      else begin cyc(); k++; end
    end
    checks++;
    if (!seen || sb.size() == 0) begin
      failures++;
      $display("FAIL cdb_hold_timeout: seen=%b pending=%0d required 1 1", seen, sb.size());
      return;
    end
    e = sb.pop_front();
    ld_req = 1'b1; ld_addr = 32'h11C; ld_tag = 4'd11;
    st_req = 1'b1; st_addr = 32'h210; st_data = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (cdb_req !== 1'b1 || cdb_tag !== e.tag || cdb_val !== e.val ||
          ld_gnt !== 1'b0 || st_gnt !== 1'b0) begin
        failures++;
        $display("FAIL cdb_hold_%0d: req=%b tag=%0d val=%h gnt=%b%b required 1 %0d %h 00",
                 i, cdb_req, cdb_tag, cdb_val, ld_gnt, st_gnt, e.tag, e.val);
      end
      cyc();
    end
    cdb_ack = 1'b1;
    #1;
    checks++;
    if (ld_gnt !== 1'b0 || st_gnt !== 1'b0) begin
      failures++;
      $display("FAIL cdb_hold_ack_cycle: gnt=%b%b required 00", ld_gnt, st_gnt);
    end
    cyc();
    cdb_ack = 1'b0;
    #1;
    checks++;
    if (st_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      failures++;
      $display("FAIL cdb_hold_next_grant: ld=%b st=%b required ld=0 st=1", ld_gnt, st_gnt);
    end
    ref_mem[8'h84] = 32'h0BADF00D;
    cyc();
    ld_req = 1'b0; st_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    bc_t e;
    issue_load(32'h11C, 4'd4, 1'b0, "rst_mid");
    ld_req = 1'b1; ld_addr = 32'h120; ld_type = 3'b010; ld_tag = 4'd10;
    st_req = 1'b1; st_addr = 32'h214; st_data = 32'h55AA55AA;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || cdb_tag !== INVALID || cdb_req !== 1'b0 || cdb_val !== 32'h0 ||
        ld_gnt !== 1'b0 || st_gnt !== 1'b0 || mem_rden2 !== 1'b0 || mem_we2 !== 1'b0 ||
        mem_addr2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_async: busy=%b tag=%0d req=%b gnt=%b%b rden=%b we=%b addr=%h %s",
               busy, cdb_tag, cdb_req, ld_gnt, st_gnt, mem_rden2, mem_we2, mem_addr2,
               "required all 0 and tag 15");
    end
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (ld_gnt !== 1'b1 || st_gnt !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_first_grant: ld=%b st=%b required ld=1 st=0", ld_gnt, st_gnt);
    end
    e.tag = 4'd10; e.val = ref_mem[8'h48];
    sb.push_back(e);
    cyc();
    ld_req = 1'b0; st_req = 1'b0;
    collect_bcast("rst_mid_load");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE0000 | i;
      ref_mem[i] = 32'hC0DE0000 | i;
    end
    rst = 1'b1; ld_req = 1'b0; st_req = 1'b0; flush = 1'b0; cdb_ack = 1'b0;
    ld_addr = '0; ld_type = '0; ld_tag = '0;
    st_addr = '0; st_data = '0; st_size = '0;
    test_reset();
    test_load_basic();
    test_store();
    test_arbitration();
    test_flush();
    test_cdb_hold();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d broadcasts outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
